// File: rtl/lc3b_types.sv
// Shared cache-geometry types: way index, tag width and way count.
package lc3b_types;

    typedef logic [2:0]  lc3b_c_index;
    typedef logic [11:0] lc3b_c_tag;

    localparam int C_WAYS = 8;

endpackage

// File: rtl/fa_tag_lookup_plru_tree8.sv
// Combinational tree pseudo-LRU helpers for an 8-way set.
// plru[0] is the root, [1]/[2] choose within ways 0-3 / 4-7,
// [3]..[6] choose within pairs 0-1, 2-3, 4-5, 6-7.
// A bit value of 1 steers the victim to the upper half of its subtree.
module plru_tree8
    import lc3b_types::*;
(
    input  logic [6:0]  plru_i,
    input  lc3b_c_index touch_way_i,
    output lc3b_c_index victim_o,
    output logic [6:0]  plru_o
);

    function automatic lc3b_c_index victim_of(input logic [6:0] p);
        logic r;
        logic m;
        logic l;
        r = p[0];
        m = r ? p[2] : p[1];
        case ({r, m})
            2'b00:   l = p[3];
            2'b01:   l = p[4];
            2'b10:   l = p[5];
            default: l = p[6];
        endcase
        return {r, m, l};
    endfunction

    // Every node on the path to the touched way is pointed away from it.
    function automatic logic [6:0] touch(input logic [6:0] p, input lc3b_c_index w);
        logic [6:0] n;
        n    = p;
        n[0] = ~w[2];
        if (w[2]) n[2] = ~w[1];
        else      n[1] = ~w[1];
        case (w[2:1])
            2'b00:   n[3] = ~w[0];
            2'b01:   n[4] = ~w[0];
            2'b10:   n[5] = ~w[0];
            default: n[6] = ~w[0];
        endcase
        return n;
    endfunction

    // Victim selection and touch update are pure functions of the current tree.
    always_comb begin
        victim_o = victim_of(plru_i);
        plru_o   = touch(plru_i, touch_way_i);
    end

endmodule

// File: rtl/fa_tag_lookup.sv
// Tag store and lookup engine for the 8-way fully associative cache.
// Answers lookups with hit/way or a victim way one cycle after acceptance;
// fills install tags, flush invalidates everything. flush > fill > lookup.
module fa_tag_lookup
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  lc3b_c_tag   req_tag,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_hit,
    output lc3b_c_index resp_index,
    input  logic        fill_valid,
    input  lc3b_c_tag   fill_tag,
    input  lc3b_c_index fill_index,
    input  logic        flush
);

    logic [C_WAYS-1:0] valid_q, valid_d;
    lc3b_c_tag         tag_q [C_WAYS];
    logic [6:0]        plru_q, plru_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    lc3b_c_index       resp_index_q, resp_index_d;

    logic              accept;
    logic              lk_hit;
    lc3b_c_index       lk_hit_idx;
    logic              any_inv;
    lc3b_c_index       inv_idx;
    lc3b_c_index       plru_victim;
    lc3b_c_index       touch_way;
    logic [6:0]        plru_touched;

    assign req_ready  = rst_n & ~flush & ~fill_valid & (~resp_valid_q | resp_ready);
    assign accept     = req_valid & req_ready;
    assign touch_way  = fill_valid ? fill_index : lk_hit_idx;

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_index = resp_index_q;

    plru_tree8 u_plru (
        .plru_i      (plru_q),
        .touch_way_i (touch_way),
        .victim_o    (plru_victim),
        .plru_o      (plru_touched)
    );

    // Parallel tag match and invalid-way search; lowest index wins in both.
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_idx = '0;
        any_inv    = 1'b0;
        inv_idx    = '0;
        for (int i = C_WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                lk_hit     = 1'b1;
                lk_hit_idx = lc3b_c_index'(i);
            end
            if (!valid_q[i]) begin
                any_inv = 1'b1;
                inv_idx = lc3b_c_index'(i);
            end
        end
    end

    // Next-state for valid bits, PLRU tree and the response register.
    always_comb begin
        valid_d      = valid_q;
        plru_d       = plru_q;
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;

        if (flush) begin
            valid_d = '0;
            plru_d  = '0;
        end else if (fill_valid) begin
            valid_d[fill_index] = 1'b1;
            plru_d              = plru_touched;
        end else if (accept && lk_hit) begin
            plru_d = plru_touched;
        end

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = lk_hit;
            if (lk_hit)       resp_index_d = lk_hit_idx;
            else if (any_inv) resp_index_d = inv_idx;
            else              resp_index_d = plru_victim;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control and response state, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            plru_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
        end else begin
            valid_q      <= valid_d;
            plru_q       <= plru_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
        end
    end

    // Tag storage is not reset; a fill dropped by flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (fill_valid && !flush) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_fa_tag_lookup.sv
// Directed bench for fa_tag_lookup: a table of fill/lookup records plus
// hand-written sequences for backpressure, fill/flush priority and reset.
module tb_fa_tag_lookup;
    import lc3b_types::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    lc3b_c_tag   req_tag;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    lc3b_c_index resp_index;
    logic        fill_valid;
    lc3b_c_tag   fill_tag;
    lc3b_c_index fill_index;
    logic        flush;

    int checks = 0;
    int errors = 0;

    fa_tag_lookup dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .fill_valid (fill_valid),
        .fill_tag   (fill_tag),
        .fill_index (fill_index),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_fill;
        logic [11:0] tag;
        logic [2:0]  idx;
        logic        exp_hit;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a fill for one edge.
    task automatic do_fill(input logic [11:0] t, input logic [2:0] w);
        fill_valid = 1'b1;
        fill_tag   = t;
        fill_index = w;
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    // Issue one lookup and check the response right after the accepting edge.
    task automatic do_lookup(input string name, input logic [11:0] t,
                             input logic eh, input logic [2:0] ei);
        req_valid  = 1'b1;
        req_tag    = t;
        resp_ready = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({name, "_vld"}, resp_valid, 1);
        chk({name, "_hit"}, resp_hit, eh);
        chk({name, "_idx"}, resp_index, ei);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_tag    = 12'h0;
        resp_ready = 1'b1;
        fill_valid = 1'b0;
        fill_tag   = 12'h0;
        fill_index = 3'd0;
        flush      = 1'b0;

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_index", resp_index, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First lookup on an empty array: miss, lowest invalid way
        do_lookup("empty", 12'h0A5, 1'b0, 3'd0);

        // Table: fill every way, then exercise hits and PLRU victims
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 12'h100 + 12'(i), 3'(i), 1'b0, 3'd0});
        vecs.push_back('{1'b0, 12'h1FF, 3'd0, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 12'h100, 3'd0, 1'b1, 3'd0});
        vecs.push_back('{1'b0, 12'h1FF, 3'd0, 1'b0, 3'd4});
        vecs.push_back('{1'b0, 12'h107, 3'd0, 1'b1, 3'd7});
        vecs.push_back('{1'b0, 12'h1FF, 3'd0, 1'b0, 3'd2});
        vecs.push_back('{1'b1, 12'h103, 3'd5, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 12'h103, 3'd0, 1'b1, 3'd3});
        vecs.push_back('{1'b0, 12'h1FF, 3'd0, 1'b0, 3'd6});
        vecs.push_back('{1'b0, 12'h105, 3'd0, 1'b0, 3'd6});

        foreach (vecs[i]) begin
            if (vecs[i].is_fill)
                do_fill(vecs[i].tag, vecs[i].idx);
            else
                do_lookup($sformatf("vec%0d", i), vecs[i].tag, vecs[i].exp_hit, vecs[i].exp_idx);
        end

        // Backpressure: response held, request stalled, then accepted
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_tag    = 12'h100;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_tag = 12'h107;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_rdy%0d", c), req_ready, 0);
            chk($sformatf("bp_vld%0d", c), resp_valid, 1);
            chk($sformatf("bp_hit%0d", c), resp_hit, 1);
            chk($sformatf("bp_idx%0d", c), resp_index, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_rdy", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_vld", resp_valid, 1);
        chk("bp_next_hit", resp_hit, 1);
        chk("bp_next_idx", resp_index, 7);

        // Fill and request in the same cycle: fill wins, lookup follows
        fill_valid = 1'b1;
        fill_tag   = 12'h2AB;
        fill_index = 3'd1;
        req_valid  = 1'b1;
        req_tag    = 12'h2AB;
        #1;
        chk("fillreq_rdy", req_ready, 0);
        @(posedge clk); #1;
        fill_valid = 1'b0;
        chk("fillreq_resp_cleared", resp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("fillreq_vld", resp_valid, 1);
        chk("fillreq_hit", resp_hit, 1);
        chk("fillreq_idx", resp_index, 1);

        // Flush with a fill: everything invalid, fill dropped
        flush      = 1'b1;
        fill_valid = 1'b1;
        fill_tag   = 12'h3CC;
        fill_index = 3'd2;
        #1;
        chk("flush_rdy", req_ready, 0);
        @(posedge clk); #1;
        flush      = 1'b0;
        fill_valid = 1'b0;
        do_lookup("flush_old", 12'h100, 1'b0, 3'd0);
        do_lookup("flush_drop", 12'h3CC, 1'b0, 3'd0);

        // Reset during a pending response
        do_fill(12'h555, 3'd3);
        req_valid  = 1'b1;
        req_tag    = 12'h555;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("midrst_pending", resp_valid, 1);
        chk("midrst_pending_hit", resp_hit, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", resp_valid, 0);
        chk("midrst_rdy", req_ready, 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        do_lookup("midrst_l1", 12'h555, 1'b0, 3'd0);
        do_lookup("midrst_l2", 12'h2AB, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fa_tag_lookup.md
# fa_tag_lookup

Tag store and lookup engine for the 8-way fully associative cache array. It holds one tag and one valid bit per way and answers lookup requests with hit/way, or with a victim way on a miss. It keeps tree pseudo-LRU replacement state and accepts fill commands that install a tag into a way. The cache controller uses the returned index to drive the write and index inputs of the fully associative data array.

## Interface
- No parameters. Geometry is fixed by the shared package: 8 ways, 3-bit `lc3b_c_index`, 12-bit `lc3b_c_tag`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  lookup request present.
- `req_tag`  in  12  tag to look up.
- `req_ready`  out  1  lookup accepted this cycle when `req_valid & req_ready`.
- `resp_valid`  out  1  registered response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_hit`  out  1  1 = tag matched a valid way.
- `resp_index`  out  3  hit way on a hit; victim way on a miss.
- `fill_valid`  in  1  install `fill_tag` into `fill_index` this cycle.
- `fill_tag`  in  12  tag to install.
- `fill_index`  in  3  target way.
- `flush`  in  1  invalidate all ways.

## Operation
- State:
  - `valid[7:0]`, `tag[7:0]` (12 bits each).
  - `plru[6:0]`: bit 0 is the root, bits 1/2 cover ways 0-3/4-7, bits 3..6 cover the pairs 0-1, 2-3, 4-5, 6-7.
  - PLRU bit = 1 means the victim lies in the upper half.
- Lookup, on acceptance:
  - Compare `req_tag` against all valid ways using pre-edge state.
  - On a hit, register `resp_hit=1` and `resp_index` = the matching way. If several ways match, the lowest index wins.
  - On a miss, register `resp_hit=0` and `resp_index` = victim.
  - Victim = the lowest-index invalid way if any exists; otherwise follow the PLRU tree from the root.
- PLRU touch: on a lookup hit and on every fill, set each bit on the path to the accessed way so it points away from that way. A miss does not touch PLRU.
- Fill: `tag[fill_index] <= fill_tag`, `valid[fill_index] <= 1`, then PLRU touch. No duplicate-tag check; avoiding duplicates is the caller's responsibility.
- Flush: `valid <= 0` and `plru <= 0`. Tags are left unchanged. A pending response is not cancelled.
- Priority, same cycle:
  - flush > fill > lookup.
  - `req_ready=0` whenever `flush` or `fill_valid` is high.
  - `fill_valid` together with `flush`: the fill is dropped.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `valid=0`, `plru=0`, `resp_valid=0`, `resp_hit=0`, `resp_index=0`.
  - `req_ready=0` while `rst_n=0`.
  - Tags are not reset.
- `req_ready = rst_n & ~flush & ~fill_valid & (~resp_valid | resp_ready)`. It is combinational from inputs and `resp_valid`.
- Latency: a request accepted on edge t has its response visible after edge t, i.e. one cycle.
- Throughput: one lookup per cycle when `resp_ready` is held high.
- `resp_*` are held stable while `resp_valid & ~resp_ready`.
- `resp_valid` clears on an edge with `resp_ready=1` and no new acceptance. It stays 1 on back-to-back acceptance.
- A fill on edge t is visible to lookups accepted on edge t+1 and later.
- A victim returned on a miss can differ from the way a later fill picks. Consistency is the controller's job.
- Reset asserted mid-operation drops any pending response. There is no recovery state.

## Structure
- `lc3b_types` gains `lc3b_c_tag` (logic [11:0]) and the constant `C_WAYS = 8`. It reuses `lc3b_c_index`.
- Sub-module `plru_tree8` holds the combinational victim-select and touch-update functions over `plru[6:0]`. The register itself stays in `fa_tag_lookup`.

## Test plan
- Reset, then lookup tag 12'h0A5 → `resp_valid=1`, `resp_hit=0`, `resp_index=0`, one cycle after acceptance.
- Fill ways 0..7 with tags 12'h100..12'h107 in order, then lookup 12'h1FF → miss, `resp_index=0` (PLRU=0 after the last fill).
- Continue: lookup 12'h100 → hit, index 0. Then lookup 12'h1FF → miss, `resp_index=4`.
- Hold `resp_ready=0` with a response pending and `req_valid=1` → `req_ready=0`, `resp_*` unchanged for 3 cycles. Raise `resp_ready` → next request accepted the same cycle.
- `fill_valid` and `req_valid` in the same cycle → `req_ready=0` and the fill is applied. A lookup of the filled tag on the next cycle → hit at `fill_index`.
- `flush` with `fill_valid` set, then lookup a previously present tag → miss, `resp_index=0`, fill dropped.
- `rst_n` dropped while `resp_valid=1` → `resp_valid=0` immediately, and every lookup afterwards misses.
